twiddle_const_mult: RTL and testbench

//   Constant complex multipliers for the FFT butterfly path, both sharing one input sample.

---
 rtl/twiddle_const_mult.sv | 136 +++++++++++++
 tb/tb_twiddle_const_mult.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_const_mult.sv
// Shift-add constant complex multipliers: W64^3 and W8^1 paths on one
// shared sample. Two register stages, one sample per clock.
//
// Ports:
//   clk, rst (sync, active-high), in_valid -> out_valid (2-cycle tag)
//   din_real/din_imag        : signed DATA_WIDTH input sample
//   dout_rere/imim/reim/imre : rounded partial products (C3/S3)
//   dout_real/dout_imag      : saturated W64^3 product
//   d45_real/d45_imag        : saturated 45-degree rotation
module twiddle_const_mult #(
  parameter int DATA_WIDTH = 18,
  parameter int COEF_FRAC  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] din_real,
  input  logic signed [DATA_WIDTH-1:0] din_imag,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] dout_rere,
  output logic signed [DATA_WIDTH-1:0] dout_imim,
  output logic signed [DATA_WIDTH-1:0] dout_reim,
  output logic signed [DATA_WIDTH-1:0] dout_imre,
  output logic signed [DATA_WIDTH-1:0] dout_real,
  output logic signed [DATA_WIDTH-1:0] dout_imag,
  output logic signed [DATA_WIDTH-1:0] d45_real,
  output logic signed [DATA_WIDTH-1:0] d45_imag
);

  localparam int DW = DATA_WIDTH;
  // Full-precision product width: DW+1 operand times a sub-unity
  // constant of COEF_FRAC+1 bits.
  localparam int PW = DW + COEF_FRAC + 2;
  localparam int RW = PW - COEF_FRAC;

  localparam real SC = 2.0 ** COEF_FRAC;
  localparam int C3 =
    int'($floor(0.9569403357322088 * SC + 0.5));
  localparam int S3 =
    int'($floor(0.2902846772544623 * SC + 0.5));
  localparam int C45 =
    int'($floor(0.7071067811865476 * SC + 0.5));

  localparam logic signed [PW-1:0] HALF =
    PW'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [PW-1:0] MAXV =
    (PW'(1) <<< (DW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV =
    -(PW'(1) <<< (DW - 1));

  // Constant multiply unrolled into shifted adds of the set bits.
  function automatic logic signed [PW-1:0] cmul(
    input logic signed [PW-1:0] x,
    input int                   c
  );
    logic signed [PW-1:0] acc;
    acc = '0;
    for (int b = 0; b <= COEF_FRAC; b++)
      if (c[b]) acc = acc + (x <<< b);
    return acc;
  endfunction

  // floor(p / 2^COEF_FRAC + 0.5)
  function automatic logic signed [PW-1:0] rnd(
    input logic signed [PW-1:0] p
  );
    return (p + HALF) >>> COEF_FRAC;
  endfunction

  function automatic logic signed [DW-1:0] sat(
    input logic signed [PW-1:0] v
  );
    if (v > MAXV) return MAXV[DW-1:0];
    if (v < MINV) return MINV[DW-1:0];
    return DW'(v);
  endfunction

  logic signed [PW-1:0] ext_re, ext_im;
  logic signed [PW-1:0] sum_b, dif_b;
  logic signed [DW-1:0] rere_d, imim_d, reim_d, imre_d;
  logic signed [DW-1:0] rere_q, imim_q, reim_q, imre_q;
  logic signed [RW-1:0] p45r_d, p45i_d, p45r_q, p45i_q;
  logic                 v_q;

  always_comb begin
    ext_re = PW'(din_real);
    ext_im = PW'(din_imag);
    sum_b  = ext_re + ext_im;
    dif_b  = ext_im - ext_re;
    rere_d = DW'(rnd(cmul(ext_re, C3)));
    imim_d = DW'(rnd(cmul(ext_im, S3)));
    reim_d = DW'(rnd(cmul(ext_re, S3)));
    imre_d = DW'(rnd(cmul(ext_im, C3)));
    p45r_d = RW'(rnd(cmul(sum_b, C45)));
    p45i_d = RW'(rnd(cmul(dif_b, C45)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rere_q    <= '0;
      imim_q    <= '0;
      reim_q    <= '0;
      imre_q    <= '0;
      p45r_q    <= '0;
      p45i_q    <= '0;
      v_q       <= 1'b0;
      out_valid <= 1'b0;
      dout_rere <= '0;
      dout_imim <= '0;
      dout_reim <= '0;
      dout_imre <= '0;
      dout_real <= '0;
      dout_imag <= '0;
      d45_real  <= '0;
      d45_imag  <= '0;
    end else begin
      rere_q    <= rere_d;
      imim_q    <= imim_d;
      reim_q    <= reim_d;
      imre_q    <= imre_d;
      p45r_q    <= p45r_d;
      p45i_q    <= p45i_d;
      v_q       <= in_valid;
      out_valid <= v_q;
      dout_rere <= rere_q;
      dout_imim <= imim_q;
      dout_reim <= reim_q;
      dout_imre <= imre_q;
      dout_real <= sat(PW'(rere_q) + PW'(imim_q));
      dout_imag <= sat(PW'(imre_q) - PW'(reim_q));
      d45_real  <= sat(PW'(p45r_q));
      d45_imag  <= sat(PW'(p45i_q));
    end
  end

endmodule

// File: tb/tb_twiddle_const_mult.sv
// Bench for twiddle_const_mult: directed spec vectors, rounding sweep,
// random back-to-back stream and mid-stream reset vs a reference model.
module tb_twiddle_const_mult;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [17:0]  din_real = '0;
  logic signed [17:0]  din_imag = '0;
  logic                out_valid;
  logic signed [17:0]  dout_rere, dout_imim, dout_reim, dout_imre;
  logic signed [17:0]  dout_real, dout_imag, d45_real, d45_imag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  twiddle_const_mult #(.DATA_WIDTH(18), .COEF_FRAC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .din_real(din_real), .din_imag(din_imag),
    .out_valid(out_valid),
    .dout_rere(dout_rere), .dout_imim(dout_imim),
    .dout_reim(dout_reim), .dout_imre(dout_imre),
    .dout_real(dout_real), .dout_imag(dout_imag),
    .d45_real(d45_real), .d45_imag(d45_imag)
  );

  logic [143:0] act;
  assign act = {dout_rere, dout_imim, dout_reim, dout_imre,
                dout_real, dout_imag, d45_real, d45_imag};

  function automatic logic [143:0] pk(
    input longint a, input longint b, input longint c,
    input longint d, input longint e, input longint f,
    input longint g, input longint h);
    return {18'(a), 18'(b), 18'(c), 18'(d),
            18'(e), 18'(f), 18'(g), 18'(h)};
  endfunction

  // floor(p/65536 + 0.5) by exact integer floor division
  function automatic longint m_rnd(input longint p);
    longint n, q;
    n = p + 32768;
    q = n / 65536;
    if (n < 0 && q * 65536 != n) q = q - 1;
    return q;
  endfunction

  function automatic longint m_sat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic logic [143:0] model(input int re, input int im);
    longint rr, ii, ri, ir;
    rr = m_rnd(longint'(re) * 62714);
    ii = m_rnd(longint'(im) * 19024);
    ri = m_rnd(longint'(re) * 19024);
    ir = m_rnd(longint'(im) * 62714);
    return pk(rr, ii, ri, ir, m_sat(rr + ii), m_sat(ir - ri),
              m_sat(m_rnd((longint'(re) + im) * 46341)),
              m_sat(m_rnd((longint'(im) - re) * 46341)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int re, input int im, input logic v);
    din_real = 18'(re);
    din_imag = 18'(im);
    in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(12345, -777, 1'b1);
    step();
    step();
    checks++;
    if (act !== 144'd0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", act);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [143:0] want [4];
    int re [4];
    int im [4];
    re[0] = 100000;  im[0] = -100000;
    want[0] = pk(95694, -29028, 29028, -95694,
                 66666, -124722, 0, -131072);
    re[1] = 0;       im[1] = 0;
    want[1] = pk(0, 0, 0, 0, 0, 0, 0, 0);
    re[2] = 65536;   im[2] = 0;
    want[2] = pk(62714, 0, 19024, 0,
                 62714, -19024, 46341, -46341);
    re[3] = -131072; im[3] = -131072;
    want[3] = pk(-125428, -38048, -38048, -125428,
                 -131072, -87380, -131072, 0);
    for (int i = 0; i < 4; i++) begin
      drive(re[i], im[i], 1'b1);
      step();
      step();
      checks++;
      if (act !== want[i]) begin
        errors++;
        $display("FAIL directed%0d got=%h want=%h", i, act, want[i]);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_valid got=%b want=1",
                 i, out_valid);
      end
    end
  endtask

  task automatic test_rounding();
    int vals [$];
    logic [143:0] want;
    for (int k = 0; k < 17; k++) begin
      vals.push_back(1 << k);
      vals.push_back(-(1 << k));
    end
    vals.push_back(3);
    vals.push_back(-3);
    vals.push_back(131071);
    vals.push_back(-131072);
    // hand-derived half-LSB behaviour around +/-1
    drive(1, 0, 1'b1);
    step();
    step();
    checks++;
    if (act !== pk(1, 0, 0, 0, 1, 0, 1, -1)) begin
      errors++;
      $display("FAIL round_p1 got=%h want=%h",
               act, pk(1, 0, 0, 0, 1, 0, 1, -1));
    end
    drive(-1, 0, 1'b1);
    step();
    step();
    checks++;
    if (act !== pk(-1, 0, 0, 0, -1, 0, -1, 1)) begin
      errors++;
      $display("FAIL round_m1 got=%h want=%h",
               act, pk(-1, 0, 0, 0, -1, 0, -1, 1));
    end
    foreach (vals[i]) begin
      drive(vals[i], 0, 1'b1);
      step();
      step();
      want = model(vals[i], 0);
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL sweep din_real=%0d got=%h want=%h",
                 vals[i], act, want);
      end
    end
  endtask

  task automatic rand_sample(output int re, output int im);
    logic [17:0] r, s;
    r = 18'($urandom);
    s = 18'($urandom);
    if ($urandom_range(7) == 0) r = 18'h20000;
    if ($urandom_range(7) == 0) s = 18'h1ffff;
    re = int'($signed(r));
    im = int'($signed(s));
  endtask

  task automatic test_back_to_back();
    int pre, pim, nre, nim;
    logic pv, nv;
    logic [143:0] want;
    pre = int'(din_real);
    pim = int'(din_imag);
    pv  = in_valid;
    for (int n = 0; n < 300; n++) begin
      rand_sample(nre, nim);
      nv = 1'($urandom);
      drive(nre, nim, nv);
      step();
      want = model(pre, pim);
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL stream%0d got=%h want=%h", n, act, want);
      end
      checks++;
      if (out_valid !== pv) begin
        errors++;
        $display("FAIL stream%0d_valid got=%b want=%b",
                 n, out_valid, pv);
      end
      pre = nre;
      pim = nim;
      pv  = nv;
    end
  endtask

  task automatic test_reset_mid();
    int r1, i1, r2, i2, r3, i3;
    logic [143:0] want;
    rand_sample(r1, i1);
    rst = 1'b1;
    drive(r1, i1, 1'b1);
    step();
    checks++;
    if (act !== 144'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_edge got=%h/%b want=0/0", act, out_valid);
    end
    rst = 1'b0;
    rand_sample(r1, i1);
    drive(r1, i1, 1'b1);
    step();
    checks++;
    if (act !== 144'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post1 got=%h/%b want=0/0", act, out_valid);
    end
    rand_sample(r2, i2);
    drive(r2, i2, 1'b0);
    step();
    want = model(r1, i1);
    checks++;
    if (act !== want || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_first got=%h/%b want=%h/1",
               act, out_valid, want);
    end
    rand_sample(r3, i3);
    drive(r3, i3, 1'b1);
    step();
    want = model(r2, i2);
    checks++;
    if (act !== want || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_second got=%h/%b want=%h/0",
               act, out_valid, want);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
